// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_access_ctrl_pkg
//  Brief   : Shared encodings and lane helpers for the data-memory access
//            controller: load/store opcodes, FSM states, exception codes,
//            misalignment test, store byte enables and store lane replication.
//  Revision: 1.0 - initial release
// ============================================================================
package dmem_access_ctrl_pkg;

    // Load operation encodings (cpu_loadOp); anything else behaves as lw
    localparam logic [2:0] c_LOP_LW  = 3'b000;
    localparam logic [2:0] c_LOP_LBU = 3'b001;
    localparam logic [2:0] c_LOP_LB  = 3'b010;
    localparam logic [2:0] c_LOP_LHU = 3'b011;
    localparam logic [2:0] c_LOP_LH  = 3'b100;

    // Store operation encodings (cpu_storeOp); 2'b11 behaves as sw
    localparam logic [1:0] c_SOP_SW  = 2'b00;
    localparam logic [1:0] c_SOP_SH  = 2'b01;
    localparam logic [1:0] c_SOP_SB  = 2'b10;

    // Exception codes reported on exc_code
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;
    localparam logic [4:0] c_EXC_DBE  = 5'd7;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    // True when the access size does not fit its natural alignment
    function automatic logic addr_misaligned(
        input logic       we,
        input logic [2:0] load_op,
        input logic [1:0] store_op,
        input logic [1:0] addr_lo
    );
        logic mis;
        mis = 1'b0;
        if (we) begin
            case (store_op)
                c_SOP_SH: mis = addr_lo[0];
                c_SOP_SB: mis = 1'b0;
                default:  mis = |addr_lo;
            endcase
        end else begin
            case (load_op)
                c_LOP_LHU, c_LOP_LH: mis = addr_lo[0];
                c_LOP_LBU, c_LOP_LB: mis = 1'b0;
                default:             mis = |addr_lo;
            endcase
        end
        return mis;
    endfunction

    // Byte enables for a store of the given size at the given byte offset
    function automatic logic [3:0] store_be(
        input logic [1:0] store_op,
        input logic [1:0] addr_lo
    );
        logic [3:0] be;
        case (store_op)
            c_SOP_SB: be = 4'b0001 << addr_lo;
            c_SOP_SH: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the low store bits across every lane they may land in
    function automatic logic [31:0] store_data(
        input logic [1:0]  store_op,
        input logic [31:0] wdata
    );
        logic [31:0] d;
        case (store_op)
            c_SOP_SB: d = {4{wdata[7:0]}};
            c_SOP_SH: d = {2{wdata[15:0]}};
            default:  d = wdata;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_load_align.sv
`default_nettype none
// ============================================================================
//  Module  : load_align
//  Brief   : Selects the addressed byte/half lane of a read word and applies
//            zero or sign extension according to the load operation.
//  Revision: 1.0 - initial release
// ============================================================================
module load_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  load_op_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the byte and halfword lanes addressed by the low address bits
    always_comb begin
        w_byte = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: w_byte = rdata_i[7:0];
            2'd1: w_byte = rdata_i[15:8];
            2'd2: w_byte = rdata_i[23:16];
            2'd3: w_byte = rdata_i[31:24];
        endcase
        w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend the selected lane; unknown load ops return the whole word
    always_comb begin
        case (load_op_i)
            c_LOP_LBU: data_o = {24'h000000, w_byte};
            c_LOP_LB:  data_o = {{24{w_byte[7]}}, w_byte};
            c_LOP_LHU: data_o = {16'h0000, w_half};
            c_LOP_LH:  data_o = {{16{w_half[15]}}, w_half};
            default:   data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_access_ctrl
//  Brief   : MEM-stage data-memory sequencer. Runs a req/ack bus cycle per
//            load/store, stalls the pipeline while it is outstanding, aligns
//            load data and reports AdEL/AdES/DBE exceptions.
//  Revision: 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_loadOp,
    input  logic [1:0]  cpu_storeOp,
    input  logic        cpu_flush,
    output logic        stall,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Counter value of the last ACCESS/DRAIN cycle allowed before abort
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [2:0]  load_op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] rdata_q;
    logic        resp_load_q;
    logic        resp_exc_q;
    logic [4:0]  exc_code_q;

    logic        w_new_req;
    logic        w_misaligned;
    logic        w_timeout;
    logic [31:0] w_load_data;

    assign w_new_req    = cpu_req && !cpu_flush;
    assign w_misaligned = addr_misaligned(cpu_we, cpu_loadOp, cpu_storeOp, cpu_addr[1:0]);
    assign w_timeout    = (cnt_q == c_TIMEOUT_LAST);

    // Lane select and extension of the returning read word
    load_align u_load_align (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .load_op_i (load_op_q),
        .data_o    (w_load_data)
    );

    // Access sequencer: request capture, bus handshake, timeout and response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            load_op_q   <= 3'd0;
            addr_lo_q   <= 2'd0;
            rdata_q     <= 32'd0;
            resp_load_q <= 1'b0;
            resp_exc_q  <= 1'b0;
            exc_code_q  <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_new_req) begin
                        load_op_q <= cpu_loadOp;
                        addr_lo_q <= cpu_addr[1:0];
                        cnt_q     <= 8'd0;
                        if (w_misaligned) begin
                            // Alignment fault: answer without touching the bus
                            resp_exc_q <= 1'b1;
                            exc_code_q <= cpu_we ? c_EXC_ADES : c_EXC_ADEL;
                            state_q    <= S_RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= cpu_we;
                            mem_addr_q  <= {cpu_addr[31:2], 2'b00};
                            mem_be_q    <= cpu_we ? store_be(cpu_storeOp, cpu_addr[1:0]) : 4'b0000;
                            mem_wdata_q <= cpu_we ? store_data(cpu_storeOp, cpu_wdata) : 32'd0;
                            state_q     <= S_ACCESS;
                        end
                    end
                end

                S_ACCESS: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (cpu_flush) begin
                            // Completed but killed: drop the result
                            state_q <= S_IDLE;
                        end else begin
                            if (!mem_we_q) begin
                                rdata_q     <= w_load_data;
                                resp_load_q <= 1'b1;
                            end
                            state_q <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        mem_req_q <= 1'b0;
                        if (cpu_flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            resp_exc_q <= 1'b1;
                            exc_code_q <= c_EXC_DBE;
                            state_q    <= S_RESP;
                        end
                    end else if (cpu_flush) begin
                        // Bus cycle already issued: keep it open until it ends
                        state_q <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_ack || w_timeout) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end

                S_RESP: begin
                    resp_load_q <= 1'b0;
                    resp_exc_q  <= 1'b0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Pipeline freeze and flush-masked response pulses
    always_comb begin
        stall       = ((state_q == S_IDLE) && w_new_req)
                    || (state_q == S_ACCESS)
                    || (state_q == S_DRAIN);
        rdata_valid = (state_q == S_RESP) && resp_load_q && !cpu_flush;
        exc_valid   = (state_q == S_RESP) && resp_exc_q && !cpu_flush;
    end

    assign rdata     = rdata_q;
    assign exc_code  = exc_code_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_access_ctrl
//  Brief   : Directed scoreboard bench for dmem_access_ctrl. Stimulus pushes
//            expected responses and bus requests; a monitor pops and compares.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int unsigned c_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_flush;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_loadOp;
    logic [1:0]  cpu_storeOp;
    logic        stall, rdata_valid, exc_valid;
    logic [31:0] rdata;
    logic [4:0]  exc_code;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        bit          is_exc;
        logic [31:0] val;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t exp_q[$];
    bus_t  bus_q[$];
    resp_t mon_r;
    bus_t  mon_b;
    logic  mem_req_prev = 1'b0;
    int    n_pass  = 0;
    int    n_total = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_loadOp  (cpu_loadOp),
        .cpu_storeOp (cpu_storeOp),
        .cpu_flush   (cpu_flush),
        .stall       (stall),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic push_rd(input logic [31:0] v);
        resp_t r;
        r.is_exc = 1'b0; r.val = v;
        exp_q.push_back(r);
    endtask

    task automatic push_exc(input logic [4:0] code);
        resp_t r;
        r.is_exc = 1'b1; r.val = {27'd0, code};
        exp_q.push_back(r);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    // Monitor: response pulses and the first cycle of every bus request
    always @(negedge clk) begin
        if (!reset) begin
            if (rdata_valid || exc_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pulse: got rdata_valid=%0b exc_valid=%0b rdata=0x%08h exc_code=%0d, expected no pulse",
                             rdata_valid, exc_valid, rdata, exc_code);
                end else begin
                    mon_r = exp_q.pop_front();
                    if (mon_r.is_exc) begin
                        check("exc_valid", {31'd0, exc_valid}, 32'd1);
                        check("exc_code", {27'd0, exc_code}, mon_r.val);
                        check("no_rdata_with_exc", {31'd0, rdata_valid}, 32'd0);
                    end else begin
                        check("rdata_valid", {31'd0, rdata_valid}, 32'd1);
                        check("rdata", rdata, mon_r.val);
                        check("no_exc_with_rdata", {31'd0, exc_valid}, 32'd0);
                    end
                end
            end
            if (mem_req && !mem_req_prev) begin
                if (bus_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_mem_req: got mem_req=1 addr=0x%08h, expected no request", mem_addr);
                end else begin
                    mon_b = bus_q.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, mon_b.we});
                    check("mem_addr", mem_addr, mon_b.addr);
                    check("mem_be", {28'd0, mem_be}, {28'd0, mon_b.be});
                    if (mon_b.we) check("mem_wdata", mem_wdata, mon_b.wdata);
                end
            end
        end
        mem_req_prev = mem_req;
    end

    // One CPU access; the bus model acks after ack_at request cycles (-1 never)
    task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] lop, input logic [1:0] sop, input int ack_at,
                          input logic [31:0] rd, input int flush_at, input bit flush_resp,
                          output int n_stall, output int n_req);
        bit done, acked, flushed;
        n_stall = 0; n_req = 0; done = 0; acked = 0; flushed = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_loadOp = lop; cpu_storeOp = sop;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            cpu_flush = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            if (flushed) cpu_req = 1'b0;
            if (acked && flush_resp) cpu_flush = 1'b1;
            acked = 0;
            if (mem_req) begin
                if (n_req == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rd; acked = 1;
                end
                if (n_req == flush_at) begin
                    cpu_flush = 1'b1; flushed = 1;
                end
                n_req++;
            end
            @(negedge clk);
            if (stall) n_stall++;
            else done = 1;
        end
        check("op_completed", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_flush = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        int ns, nr;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_flush = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_loadOp = 3'd0; cpu_storeOp = 2'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_valids", {30'd0, rdata_valid, exc_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus", {mem_addr[27:0], mem_be}, 32'd0);
        check("rst_exc_code", {27'd0, exc_code}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // lb 0x1003, immediate ack
        push_bus(1'b0, 32'h0000_1000, 4'b0000, 32'd0);
        push_rd(32'hFFFF_FF80);
        run_op(1'b0, 32'h0000_1003, 32'd0, 3'b010, 2'b00, 0, 32'h80FF_0000, -1, 0, ns, nr);
        check("lb_stall_cycles", ns, 2);

        // sh 0x2002, ack on the second request cycle; stores pulse nothing
        push_bus(1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
        run_op(1'b1, 32'h0000_2002, 32'h0000_BEEF, 3'b000, 2'b01, 1, 32'd0, -1, 0, ns, nr);
        check("sh_req_cycles", nr, 2);

        // Misaligned lw / sw / lh / sh: no bus cycle
        push_exc(5'd4);
        run_op(1'b0, 32'h0000_0006, 32'd0, 3'b000, 2'b00, 0, 32'd0, -1, 0, ns, nr);
        check("adel_lw_no_req", nr, 0);
        check("adel_lw_stall", ns, 1);
        push_exc(5'd5);
        run_op(1'b1, 32'h0000_0001, 32'd0, 3'b000, 2'b00, 0, 32'd0, -1, 0, ns, nr);
        check("ades_sw_no_req", nr, 0);
        push_exc(5'd4);
        run_op(1'b0, 32'h0000_0003, 32'd0, 3'b100, 2'b00, 0, 32'd0, -1, 0, ns, nr);
        push_exc(5'd5);
        run_op(1'b1, 32'h0000_0005, 32'd0, 3'b000, 2'b01, 0, 32'd0, -1, 0, ns, nr);

        // sb lane, sw via undefined storeOp, extension variants
        push_bus(1'b1, 32'h0000_3000, 4'b0010, 32'h7878_7878);
        run_op(1'b1, 32'h0000_3001, 32'h1234_5678, 3'b000, 2'b10, 0, 32'd0, -1, 0, ns, nr);
        push_bus(1'b1, 32'h0000_0030, 4'b1111, 32'h1122_3344);
        run_op(1'b1, 32'h0000_0030, 32'h1122_3344, 3'b000, 2'b11, 0, 32'd0, -1, 0, ns, nr);
        push_bus(1'b0, 32'h0000_0010, 4'b0000, 32'd0);
        push_rd(32'hFFFF_8001);
        run_op(1'b0, 32'h0000_0010, 32'd0, 3'b100, 2'b00, 0, 32'h0000_8001, -1, 0, ns, nr);
        push_bus(1'b0, 32'h0000_0010, 4'b0000, 32'd0);
        push_rd(32'h0000_00CC);
        run_op(1'b0, 32'h0000_0011, 32'd0, 3'b001, 2'b00, 2, 32'hAABB_CCDD, -1, 0, ns, nr);
        push_bus(1'b0, 32'h0000_0020, 4'b0000, 32'd0);
        push_rd(32'hCAFE_F00D);
        run_op(1'b0, 32'h0000_0020, 32'd0, 3'b000, 2'b00, 0, 32'hCAFE_F00D, -1, 0, ns, nr);
        push_bus(1'b0, 32'h0000_0024, 4'b0000, 32'd0);
        push_rd(32'h0102_0304);
        run_op(1'b0, 32'h0000_0024, 32'd0, 3'b111, 2'b00, 0, 32'h0102_0304, -1, 0, ns, nr);

        // Bus timeout: request held exactly TIMEOUT cycles, then DBE
        push_bus(1'b0, 32'h0000_0100, 4'b0000, 32'd0);
        push_exc(5'd7);
        run_op(1'b0, 32'h0000_0100, 32'd0, 3'b000, 2'b00, -1, 32'd0, -1, 0, ns, nr);
        check("timeout_req_cycles", nr, 4);
        check("timeout_stall_cycles", ns, 5);

        // Flush in 2nd ACCESS cycle, ack two cycles later: drain silently
        push_bus(1'b0, 32'h0000_0040, 4'b0000, 32'd0);
        run_op(1'b0, 32'h0000_0040, 32'd0, 3'b000, 2'b00, 3, 32'h5555_AAAA, 1, 0, ns, nr);
        check("drain_req_cycles", nr, 4);
        check("drain_stall_cycles", ns, 5);

        // Flush with no ack: drain ends by timeout
        push_bus(1'b0, 32'h0000_0044, 4'b0000, 32'd0);
        run_op(1'b0, 32'h0000_0044, 32'd0, 3'b000, 2'b00, -1, 32'd0, 1, 0, ns, nr);
        check("drain_to_req_cycles", nr, 4);

        // Flush together with ack: result discarded
        push_bus(1'b0, 32'h0000_0048, 4'b0000, 32'd0);
        run_op(1'b0, 32'h0000_0048, 32'd0, 3'b000, 2'b00, 0, 32'h7777_7777, 0, 0, ns, nr);
        check("flush_ack_stall_cycles", ns, 2);

        // Flush in RESP masks the load pulse
        push_bus(1'b0, 32'h0000_004C, 4'b0000, 32'd0);
        run_op(1'b0, 32'h0000_004C, 32'd0, 3'b000, 2'b00, 0, 32'h6666_6666, -1, 1, ns, nr);

        // Request with flush in IDLE is ignored
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_flush = 1'b1; cpu_addr = 32'h0000_0050; cpu_we = 1'b0; cpu_loadOp = 3'b000;
        @(negedge clk);
        check("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_flush = 1'b0;
        @(negedge clk);
        check("idle_flush_no_req", {31'd0, mem_req}, 32'd0);

        // Reset mid-ACCESS drops mem_req and stall immediately
        push_bus(1'b0, 32'h0000_0060, 4'b0000, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h0000_0060; cpu_we = 1'b0; cpu_loadOp = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        check("async_reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // lhu 0x0002 after reset: upper half, zero-extended
        push_bus(1'b0, 32'h0000_0000, 4'b0000, 32'd0);
        push_rd(32'h0000_1234);
        run_op(1'b0, 32'h0000_0002, 32'd0, 3'b011, 2'b00, 0, 32'h1234_5678, -1, 0, ns, nr);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("resp_queue_drained", exp_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
